// File: rtl/adc_tx_scheduler.sv
// adc_tx_scheduler: arbitrates between two ADC sample FIFOs (ch0 = AD9226,
// ch1 = AD9481) and streams framed bursts to a byte-wide UART transmitter.
// Frame layout: HEADER, channel id (8'h00 / 8'h01), BURST_LEN samples and,
// when FRAME_CHECKSUM_EN is defined, a trailing checksum byte (sum mod 256 of
// channel id and samples, HEADER excluded).
//
// Optional feature macro: FRAME_CHECKSUM_EN (default build: undefined).
//
// Ports:
//   CLK, RST_n            clock (rising edge), async active-low reset
//   chN_empty, chN_data   FIFO status / read data (data valid cycle after rdreq)
//   chN_rdreq             registered one-cycle FIFO read strobe
//   tx_busy               UART busy, high while a byte shifts out
//   tx_start, tx_data     registered one-cycle launch pulse and held byte
//   frame_active          high from grant until the frame's last byte completes
//   grant                 one-hot owning channel, 2'b00 when idle
module adc_tx_scheduler #(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       ch0_empty,
  input  logic [7:0] ch0_data,
  output logic       ch0_rdreq,
  input  logic       ch1_empty,
  input  logic [7:0] ch1_data,
  output logic       ch1_rdreq,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_active,
  output logic [1:0] grant
);

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] LAST_CNT = DW'(BURST_LEN - 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_HDR, S_CHID, S_FETCH, S_LOAD, S_SEND, S_WAIT_ACK,
    S_WAIT_DONE, S_CSUM
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_HDR, S_CHID, S_FETCH, S_LOAD, S_SEND, S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;
`endif

  // Which kind of byte is currently in flight; decides the step after WAIT_DONE.
  typedef enum logic [1:0] {K_HDR, K_CHID, K_SAMPLE, K_CSUM} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [1:0]      rst_sync_q, rst_sync_d;
  logic            phase_q, phase_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            last_served_q, last_served_d;  // 1: ch1 served last
  logic            tx_start_q, tx_start_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            ch0_rdreq_q, ch0_rdreq_d;
  logic            ch1_rdreq_q, ch1_rdreq_d;
  logic [1:0]      grant_q, grant_d;
  logic            frame_active_q, frame_active_d;
`ifdef FRAME_CHECKSUM_EN
  logic [DW-1:0]   csum_q, csum_d;
`endif

  logic            g_ch1;
  logic            g_empty;
  logic [DW-1:0]   g_data;
  logic            win_ch1;
  logic            end_frame;

  // Granted-channel view of the FIFO interface.
  assign g_ch1   = grant_q[1];
  assign g_empty = g_ch1 ? ch1_empty : ch0_empty;
  assign g_data  = g_ch1 ? ch1_data  : ch0_data;

  // Round-robin: ch1 wins only if non-empty and ch0 is empty or was served last.
  assign win_ch1 = !ch1_empty && (ch0_empty || !last_served_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    rst_sync_d     = {rst_sync_q[0], 1'b1};
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    last_served_d  = last_served_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    ch0_rdreq_d    = 1'b0;
    ch1_rdreq_d    = 1'b0;
    grant_d        = grant_q;
    frame_active_d = frame_active_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d         = csum_q;
`endif
    end_frame      = 1'b0;

    case (state_q)
      // Leave IDLE only once the synchronised reset release has propagated.
      S_IDLE: begin
        if (rst_sync_q[1] && (!ch0_empty || !ch1_empty)) begin
          state_d = S_ARB;
        end
      end

      S_ARB: begin
        if (ch0_empty && ch1_empty) begin
          state_d = S_IDLE;
        end else begin
          grant_d        = win_ch1 ? 2'b10 : 2'b01;
          frame_active_d = 1'b1;
          cnt_d          = '0;
`ifdef FRAME_CHECKSUM_EN
          csum_d         = '0;
`endif
          state_d        = S_HDR;
        end
      end

      S_HDR: begin
        tx_data_d = HEADER;
        kind_d    = K_HDR;
        phase_d   = 1'b0;
        state_d   = S_SEND;
      end

      S_CHID: begin
        tx_data_d = {7'd0, g_ch1};
`ifdef FRAME_CHECKSUM_EN
        csum_d    = csum_q + {7'd0, g_ch1};
`endif
        kind_d    = K_CHID;
        phase_d   = 1'b0;
        state_d   = S_SEND;
      end

      // Stall with grant held until the owning FIFO has data.
      S_FETCH: begin
        if (!g_empty) begin
          ch0_rdreq_d = !g_ch1;
          ch1_rdreq_d = g_ch1;
          phase_d     = 1'b0;
          state_d     = S_LOAD;
        end
      end

      // Phase 0 is the cycle rdreq is on the pins; FIFO data is valid in phase 1.
      S_LOAD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          tx_data_d = g_data;
`ifdef FRAME_CHECKSUM_EN
          csum_d    = csum_q + g_data;
`endif
          kind_d    = K_SAMPLE;
          phase_d   = 1'b0;
          state_d   = S_SEND;
        end
      end

      // Phase 0 waits for an idle UART; phase 1 is the cycle tx_start is high.
      S_SEND: begin
        if (!phase_q) begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            phase_d    = 1'b1;
          end
        end else begin
          phase_d = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          case (kind_q)
            K_HDR:  state_d = S_CHID;
            K_CHID: state_d = S_FETCH;
            K_SAMPLE: begin
              cnt_d = cnt_q + 8'd1;
              if (cnt_q == LAST_CNT) begin
`ifdef FRAME_CHECKSUM_EN
                state_d = S_CSUM;
`else
                end_frame = 1'b1;
`endif
              end else begin
                state_d = S_FETCH;
              end
            end
`ifdef FRAME_CHECKSUM_EN
            K_CSUM: end_frame = 1'b1;
`endif
            default: end_frame = 1'b1;
          endcase
        end
      end

`ifdef FRAME_CHECKSUM_EN
      S_CSUM: begin
        tx_data_d = csum_q;
        kind_d    = K_CSUM;
        phase_d   = 1'b0;
        state_d   = S_SEND;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Close the frame: remember the owner for round-robin and release the grant.
    if (end_frame) begin
      last_served_d  = g_ch1;
      grant_d        = 2'b00;
      frame_active_d = 1'b0;
      cnt_d          = '0;
`ifdef FRAME_CHECKSUM_EN
      csum_d         = '0;
`endif
      state_d        = S_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q        <= S_IDLE;
      kind_q         <= K_HDR;
      rst_sync_q     <= 2'b00;
      phase_q        <= 1'b0;
      cnt_q          <= '0;
      last_served_q  <= 1'b1;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      ch0_rdreq_q    <= 1'b0;
      ch1_rdreq_q    <= 1'b0;
      grant_q        <= 2'b00;
      frame_active_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      rst_sync_q     <= rst_sync_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      last_served_q  <= last_served_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      ch0_rdreq_q    <= ch0_rdreq_d;
      ch1_rdreq_q    <= ch1_rdreq_d;
      grant_q        <= grant_d;
      frame_active_q <= frame_active_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign ch0_rdreq    = ch0_rdreq_q;
  assign ch1_rdreq    = ch1_rdreq_q;
  assign grant        = grant_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_adc_tx_scheduler.sv
// tb_adc_tx_scheduler: directed bench for adc_tx_scheduler with queue-backed
// FIFO models, a busy-counter UART model and a byte log of every tx_start.
module tb_adc_tx_scheduler;

`ifdef FRAME_CHECKSUM_EN
  localparam int FB = 19;
`else
  localparam int FB = 18;
`endif

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       ch0_empty, ch1_empty;
  logic [7:0] ch0_data = 8'h00;
  logic [7:0] ch1_data = 8'h00;
  logic       ch0_rdreq, ch1_rdreq;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_active;
  logic [1:0] grant;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] txlog[$];
  logic [1:0] grlog[$];
  int         busy_len = 10;
  int         busy_cnt = 0;
  int         rd0_cnt = 0, rd1_cnt = 0, both_rd = 0, start_busy = 0, ts_cnt = 0;
  int         n_vec = 0, n_err = 0;

  always #5 CLK = ~CLK;

  adc_tx_scheduler #(.BURST_LEN(16), .HEADER(8'hA5)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .ch0_empty(ch0_empty), .ch0_data(ch0_data), .ch0_rdreq(ch0_rdreq),
    .ch1_empty(ch1_empty), .ch1_data(ch1_data), .ch1_rdreq(ch1_rdreq),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .frame_active(frame_active), .grant(grant)
  );

  assign ch0_empty = (q0.size() == 0);
  assign ch1_empty = (q1.size() == 0);

  // FIFO read model and protocol monitors, sampled mid-cycle.
  always @(negedge CLK) begin
    if (ch0_rdreq && ch1_rdreq) both_rd++;
    if (ch0_rdreq) begin
      rd0_cnt++;
      if (q0.size() > 0) ch0_data = q0.pop_front();
    end
    if (ch1_rdreq) begin
      rd1_cnt++;
      if (q1.size() > 0) ch1_data = q1.pop_front();
    end
    if (tx_start) begin
      ts_cnt++;
      if (tx_busy) start_busy++;
      txlog.push_back(tx_data);
      grlog.push_back(grant);
    end
  end

  // UART model: busy for busy_len cycles after each tx_start.
  always @(posedge CLK) begin
    if (tx_start) begin
      busy_cnt <= busy_len;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic hold_reset();
    RST_n = 1'b0;
    step(3);
  endtask

  // Release reset; the FSM must still be idle two edges later.
  task automatic release_reset(input string tag);
    RST_n = 1'b1;
    step(2);
    chk({tag, "_sync_grant"}, 32'(grant), 32'h0);
    chk({tag, "_sync_fa"}, 32'(frame_active), 32'h0);
  endtask

  task automatic wait_bytes(input string tag, input int base, input int n,
                            input bit need_idle, input int budget);
    int k = 0;
    while ((txlog.size() - base < n || (need_idle && frame_active)) && k < budget) begin
      step(1);
      k++;
    end
    chk({tag, "_in_time"}, 32'(k < budget), 32'h1);
  endtask

  task automatic push(input int ch, input logic [7:0] s0, input int step_v, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) q0.push_back(8'(int'(s0) + step_v * i));
      else         q1.push_back(8'(int'(s0) + step_v * i));
    end
  endtask

  // Check one logged frame against header, id, sample ramp and checksum.
  task automatic check_frame(input string tag, input int base, input logic [7:0] chid,
                             input logic [7:0] s0, input int step_v);
    logic [7:0] acc;
    logic [7:0] exp;
    acc = chid;
    if (txlog.size() < base + FB) begin
      chk({tag, "_len"}, 32'(txlog.size() - base), 32'(FB));
    end else begin
      chk({tag, "_hdr"}, 32'(txlog[base]), 32'hA5);
      chk({tag, "_id"}, 32'(txlog[base + 1]), 32'(chid));
      for (int i = 0; i < 16; i++) begin
        exp = 8'(int'(s0) + step_v * i);
        acc = acc + exp;
        chk($sformatf("%s_s%0d", tag, i), 32'(txlog[base + 2 + i]), 32'(exp));
      end
`ifdef FRAME_CHECKSUM_EN
      chk({tag, "_csum"}, 32'(txlog[base + 18]), 32'(acc));
`endif
    end
  endtask

  initial begin
    int base, r0, r1, ts, bad;

    // Reset values while held.
    step(2);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_rdreq", 32'({ch0_rdreq, ch1_rdreq}), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_fa", 32'(frame_active), 32'h0);

    // Single ch0 frame with ch1 empty.
    base = txlog.size(); r0 = rd0_cnt; r1 = rd1_cnt;
    push(0, 8'h01, 1, 16);
    release_reset("t1");
    wait_bytes("t1", base, FB, 1'b1, 1500);
    check_frame("t1", base, 8'h00, 8'h01, 1);
    chk("t1_rd0", 32'(rd0_cnt - r0), 32'd16);
    chk("t1_rd1", 32'(rd1_cnt - r1), 32'd0);
    chk("t1_grant", 32'(grlog[base]), 32'h1);
    chk("t1_len", 32'(txlog.size() - base), 32'(FB));

    // Round-robin with both FIFOs full from reset.
    hold_reset();
    base = txlog.size();
    push(0, 8'h20, 1, 32);
    push(1, 8'h40, 1, 16);
    release_reset("t2");
    wait_bytes("t2", base, 3 * FB, 1'b1, 4000);
    check_frame("t2f0", base, 8'h00, 8'h20, 1);
    check_frame("t2f1", base + FB, 8'h01, 8'h40, 1);
    check_frame("t2f2", base + 2 * FB, 8'h00, 8'h30, 1);
    if (grlog.size() >= base + 3 * FB) begin
      chk("t2_g0", 32'(grlog[base]), 32'h1);
      chk("t2_g1", 32'(grlog[base + FB]), 32'h2);
      chk("t2_g2", 32'(grlog[base + 2 * FB]), 32'h1);
    end
    chk("t2_idle_grant", 32'(grant), 32'h0);

    // ch0 runs dry after 5 samples; stall until refilled.
    base = txlog.size(); r0 = rd0_cnt;
    push(0, 8'h60, 1, 5);
    wait_bytes("t3a", base, 7, 1'b0, 1000);
    step(20);
    ts = ts_cnt;
    step(100);
    chk("t3_stall_start", 32'(ts_cnt - ts), 32'h0);
    chk("t3_stall_grant", 32'(grant), 32'h1);
    chk("t3_stall_fa", 32'(frame_active), 32'h1);
    chk("t3_stall_rd0", 32'(rd0_cnt - r0), 32'd5);
    push(0, 8'h65, 1, 11);
    wait_bytes("t3b", base, FB, 1'b1, 1500);
    check_frame("t3", base, 8'h00, 8'h60, 1);
    chk("t3_rd0", 32'(rd0_cnt - r0), 32'd16);

    // Long busy: no new start and stable tx_data while the UART is busy.
    busy_len = 50;
    base = txlog.size();
    push(0, 8'h80, 1, 16);
    wait_bytes("t4a", base, 1, 1'b0, 200);
    bad = 0; ts = ts_cnt;
    for (int i = 0; i < 45; i++) begin
      if (tx_start || tx_data !== 8'hA5) bad++;
      step(1);
    end
    chk("t4_hold_bad", 32'(bad), 32'h0);
    chk("t4_hold_starts", 32'(ts_cnt - ts), 32'h0);
    chk("t4_busy_still", 32'(tx_busy), 32'h1);
    wait_bytes("t4b", base, FB, 1'b1, 3000);
    check_frame("t4", base, 8'h00, 8'h80, 1);
    busy_len = 10;

    // Reset during sample 7; next frame restarts with a header.
    base = txlog.size();
    push(0, 8'h01, 1, 16);
    wait_bytes("t5a", base, 9, 1'b0, 1000);
    RST_n = 1'b0;
    #1;
    chk("t5_rst_tx_start", 32'(tx_start), 32'h0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'h0);
    chk("t5_rst_rdreq", 32'({ch0_rdreq, ch1_rdreq}), 32'h0);
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_fa", 32'(frame_active), 32'h0);
    push(0, 8'h11, 1, 7);
    step(3);
    base = txlog.size();
    release_reset("t5");
    wait_bytes("t5b", base, FB, 1'b1, 1500);
    check_frame("t5", base, 8'h00, 8'h08, 1);

    // ch1 full of 0xFF: checksum byte 0xF1 when enabled, 18-byte frame otherwise.
    base = txlog.size(); r0 = rd0_cnt;
    push(1, 8'hFF, 0, 16);
    wait_bytes("t6", base, FB, 1'b1, 1500);
    check_frame("t6", base, 8'h01, 8'hFF, 0);
`ifdef FRAME_CHECKSUM_EN
    if (txlog.size() >= base + FB) chk("t6_f1", 32'(txlog[base + 18]), 32'hF1);
`endif
    step(30);
    chk("t6_len", 32'(txlog.size() - base), 32'(FB));
    chk("t6_rd0", 32'(rd0_cnt - r0), 32'h0);

    chk("both_rdreq", 32'(both_rd), 32'h0);
    chk("start_while_busy", 32'(start_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_tx_scheduler.md
ADC_TX_SCHEDULER -- requirements
Module: adc_tx_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 16, samples per frame (legal range 1..255).
REQ-002 Parameter HEADER, default 8'hA5, first byte of every frame.
REQ-003 CLK  input  1  system clock; all logic on its rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 ch0_empty  input  1  AD9226 sample FIFO empty flag.
REQ-006 ch0_data  input  8  AD9226 FIFO read data, valid the cycle after ch0_rdreq.
REQ-007 ch0_rdreq  output  1  AD9226 FIFO read strobe.
REQ-008 ch1_empty / ch1_data / ch1_rdreq  in/in/out  1/8/1  AD9481 FIFO, same rules as ch0.
REQ-009 tx_busy  input  1  uart_tx busy, high while a byte is shifting out.
REQ-010 tx_start  output  1  one-cycle pulse launching tx_data.
REQ-011 tx_data  output  8  byte to transmit; held stable from tx_start until tx_busy falls.
REQ-012 frame_active  output  1  high from grant until last frame byte is accepted.
REQ-013 grant  output  2  one-hot owning channel; 2'b00 when idle.

Function
REQ-014 States: IDLE, ARB, HDR, CHID, FETCH, LOAD, SEND, WAIT_ACK, WAIT_DONE (plus CSUM, REQ-030).
REQ-015 IDLE->ARB when either chN_empty is 0; else remain in IDLE.
REQ-016 ARB: round-robin; exactly one non-empty channel wins; if both are non-empty, the channel not served last wins; last_served resets to ch1, so ch0 wins the first tie.
REQ-017 ARB sets grant one-hot and frame_active=1, then goes to HDR; grant is held constant for the whole frame.
REQ-018 Byte order per frame: HEADER, channel id (8'h00 ch0, 8'h01 ch1), then BURST_LEN samples.
REQ-019 Byte send: when tx_busy=0, pulse tx_start one cycle (SEND), go to WAIT_ACK.
REQ-020 Leave WAIT_ACK when tx_busy=1; leave WAIT_DONE when tx_busy=0; only then advance to the next byte.
REQ-021 tx_start never asserts while tx_busy=1 or while in WAIT_ACK/WAIT_DONE.
REQ-022 FETCH: if the granted FIFO is non-empty, pulse the granted rdreq for one cycle, go to LOAD; if empty, stall in FETCH with no timeout and grant held.
REQ-023 LOAD captures the granted chN_data into tx_data one cycle after rdreq, then goes to SEND.
REQ-024 The non-granted rdreq stays 0; at most one rdreq is high in any cycle.
REQ-025 An 8-bit sample counter counts sent samples; after sample BURST_LEN completes WAIT_DONE, update last_served, clear grant and frame_active, and return to IDLE.
REQ-026 Exactly BURST_LEN rdreq pulses are issued per frame; data is never read without being sent.

Reset
REQ-027 RST_n=0 asynchronously forces IDLE, tx_start=0, tx_data=8'h00, ch0_rdreq=ch1_rdreq=0, grant=2'b00, frame_active=0, counter=0, checksum=0, last_served=ch1.
REQ-028 Reset mid-frame abandons the frame; after release the block restarts from IDLE with no partial-frame resume.
REQ-029 Reset release is synchronised internally; the FSM leaves IDLE no earlier than the second CLK edge after RST_n rises.

Configuration
REQ-030 Macro FRAME_CHECKSUM_EN: when defined, an 8-bit checksum byte (sum mod 256 of channel id and all samples, HEADER excluded) is sent in state CSUM after the last sample, using the REQ-019/020 handshake; when undefined, the CSUM state and checksum register are absent and the frame ends after the last sample.

Verification
REQ-031 ch0 holds 16 samples 0x01..0x10, ch1 is empty, tx_busy models 10 cycles -> bytes A5,00,01..10 in order, 16 ch0_rdreq pulses, ch1_rdreq=0 throughout.
REQ-032 Both FIFOs non-empty after reset -> ch0 frame first, then ch1 frame (id 01), then ch0 again; grant alternates 01,10,01.
REQ-033 ch0 empties after 5 samples, refilled 100 cycles later -> FSM stalls in FETCH with grant=01 and no tx_start, then completes with 16 samples total.
REQ-034 tx_busy held high 50 cycles after a tx_start -> no further tx_start and tx_data unchanged until tx_busy falls.
REQ-035 RST_n pulled low during sample 7 -> all outputs at reset values immediately; next frame after release begins with A5.
REQ-036 With FRAME_CHECKSUM_EN defined and ch1 holding 16 bytes 0xFF -> checksum byte 0xF1 follows the last sample; undefined -> frame is 18 bytes.
